uart_rx_param: RTL and testbench

Parametrised UART receiver that deserialises an asynchronous serial line into parallel words. It oversamples the line using a baud-tick enable and takes mid-bit majority votes. Frame width, parity and stop bits are configurable, and parity, framing, overrun and break errors are detected. It sits between the pad-side rx line and a valid/ready consumer (FIFO or register bank), all in the single system clock domain.

---
 rtl/uart_rx_param.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised oversampling UART receiver.
//
// Deserialises an asynchronous, idle-high serial line into parallel words.
// Each bit period spans OVERSAMPLE baud_tick pulses. Three samples around the
// bit centre are combined by a 2-of-3 majority vote. Received words are
// offered on a valid/ready interface together with per-word error flags.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   baud_tick    one-clk enable pulse at OVERSAMPLE x baud rate
//   rx_in        raw serial line (idles high)
//   data_out     received word, LSB was first on the line
//   data_valid   data_out and the three per-word flags are valid
//   data_ready   consumer accepts the held word
//   parity_err   parity mismatch for the held word
//   frame_err    a stop bit was sampled low for the held word
//   break_det    all data bits, the parity bit (if any) and a stop bit were 0
//   overrun_err  one-clk pulse: a completed frame was dropped
//   busy         receiver is inside a frame (FSM not IDLE)
module uart_rx_param #(
  parameter int DATA_BITS   = 8,   // 5..9
  parameter int OVERSAMPLE  = 16,  // even, 8..32
  parameter int PARITY_MODE = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS   = 1,   // 1 or 2
  parameter int SYNC_STAGES = 2    // 2..3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

  // Tick indices inside one bit period: samples at m-1, m and m+1, where
  // m = OVERSAMPLE/2; the vote is decided at m+1.
  localparam logic [CW-1:0] TICK_LO   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] TICK_HI   = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_idx;
  logic [1:0]             smp;      // samples taken at m-1 and m
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   ferr;     // stop-bit error accumulated before the last stop bit

  logic maj;
  logic decide;
  logic last_tick;
  logic commit;
  logic data_par;
  logic word_perr;
  logic word_ferr;
  logic word_brk;

  assign rx_s = sync[SYNC_STAGES-1];
  assign busy = (state != IDLE);

  // The third vote is the live sample, so the majority is ready at tick m+1
  // without an extra register stage.
  assign maj       = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign decide    = baud_tick && (state != IDLE) && (cnt == TICK_HI);
  assign last_tick = (cnt == TICK_LAST);
  assign commit    = decide && (state == STOP) && (bit_idx == LAST_STOP);
  assign data_par  = (^shreg) ^ par_bit;
  assign word_ferr = ferr | ~maj;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    word_perr = 1'b0;
    if (PARITY_MODE == 1) begin
      word_perr = data_par;
    end else if (PARITY_MODE == 2) begin
      word_perr = ~data_par;
    end
    word_brk = (shreg == '0) && ((PARITY_MODE == 0) || !par_bit) && word_ferr;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sync        <= '1;
      armed       <= 1'b0;
      cnt         <= '0;
      bit_idx     <= '0;
      smp         <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      ferr        <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], rx_in};
      overrun_err <= 1'b0;

      // Output handshake. A commit in the same cycle overrides the drop.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (commit) begin
        if (data_valid && !data_ready) begin
          overrun_err <= 1'b1;  // new word discarded, held word untouched
        end else begin
          data_out   <= shreg;
          parity_err <= word_perr;
          frame_err  <= word_ferr;
          break_det  <= word_brk;
          data_valid <= 1'b1;
        end
      end

      if (baud_tick) begin
        if (state == IDLE) begin
          // Arming requires a high sample so a line held low cannot retrigger.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            cnt   <= '0;
          end
        end else begin
          cnt <= last_tick ? '0 : cnt + 1'b1;
          if (cnt == TICK_LO)  smp[0] <= rx_s;
          if (cnt == TICK_MID) smp[1] <= rx_s;

          case (state)
            START: begin
              if (decide && maj) begin
                state <= IDLE;  // false start: glitch shorter than half a bit
              end else if (last_tick) begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end
            DATA: begin
              if (decide) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};  // LSB arrives first
              end
              if (last_tick) begin
                if (bit_idx == LAST_DATA) begin
                  state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                  bit_idx <= '0;
                  ferr    <= 1'b0;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                end
              end
            end
            PARITY: begin
              if (decide) begin
                par_bit <= maj;
              end
              if (last_tick) begin
                state   <= STOP;
                bit_idx <= '0;
                ferr    <= 1'b0;
              end
            end
            STOP: begin
              if (decide) begin
                if (bit_idx == LAST_STOP) begin
                  // Leave mid-bit so the next start edge is caught promptly;
                  // a low final stop bit leaves the receiver disarmed.
                  state <= IDLE;
                  armed <= maj;
                end else begin
                  ferr <= ferr | ~maj;
                end
              end
              if (last_tick) begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- self-checking bench for uart_rx_param.
//
// Two receivers share clk, rst, baud_tick and data_ready: inst_a is 8N1 and
// inst_b is 7E2, both with OVERSAMPLE = 16. Serial frames are built from the
// line format rules, and expected words and flags come from a small frame
// model. A monitor collects every accepted word into a per-instance queue.
module tb_uart_rx_param;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } word_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       data_ready = 1'b0;

  logic [7:0] do_a;
  logic       dv_a, pe_a, fe_a, bk_a, ov_a, busy_a;
  logic [6:0] do_b;
  logic       dv_b, pe_b, fe_b, bk_b, ov_b, busy_b;

  int   tests_run = 0;
  int   failed = 0;
  int   tick_n = 0;
  int   start_tick = 0;
  event tick_ev;

  word_t qa[$];
  word_t qb[$];
  int    rises_a = 0;
  int    ov_cnt_a = 0;
  int    ov_cnt_b = 0;
  int    rise_tick_a = 0;
  bit    rise_on_tick_a = 1'b0;
  bit    busy_seen_a = 1'b0;
  bit    dv_a_q = 1'b0;
  logic  tick_q = 1'b0;

  uart_rx_param #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) inst_a (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_a),
    .data_out(do_a), .data_valid(dv_a), .data_ready(data_ready),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a),
    .overrun_err(ov_a), .busy(busy_a)
  );

  uart_rx_param #(
    .DATA_BITS(7), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(2), .SYNC_STAGES(2)
  ) inst_b (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_b),
    .data_out(do_b), .data_valid(dv_b), .data_ready(data_ready),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b),
    .overrun_err(ov_b), .busy(busy_b)
  );

  initial forever #5 clk = ~clk;

  // Baud tick every 4 clocks, driven on the falling edge.
  initial forever begin
    repeat (3) @(negedge clk);
    baud_tick = 1'b1;
    tick_n++;
    ->tick_ev;
    @(negedge clk);
    baud_tick = 1'b0;
  end

  always @(posedge clk) tick_q <= baud_tick;

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      dv_a_q = 1'b0;
    end else begin
      if (dv_a && data_ready) qa.push_back(word_t'{d: do_a, pe: pe_a, fe: fe_a, bk: bk_a});
      if (dv_b && data_ready) qb.push_back(word_t'{d: {1'b0, do_b}, pe: pe_b, fe: fe_b, bk: bk_b});
      if (ov_a) ov_cnt_a++;
      if (ov_b) ov_cnt_b++;
      if (busy_a) busy_seen_a = 1'b1;
      if (dv_a && !dv_a_q) begin
        rises_a++;
        rise_tick_a    = tick_n;
        rise_on_tick_a = tick_q;
      end
      dv_a_q = dv_a;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] frame_8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic word_t model_8n1(input logic [7:0] d);
    return word_t'{d: d, pe: 1'b0, fe: 1'b0, bk: 1'b0};
  endfunction

  // stop[0] is the first stop bit on the line, stop[1] the second.
  function automatic logic [15:0] frame_7e2(input logic [6:0] d, input bit flip, input logic [1:0] stop);
    logic par;
    par = (^d) ^ flip;
    return {5'b0, stop[1], stop[0], par, d, 1'b0};
  endfunction

  function automatic word_t model_7e2(input logic [6:0] d, input bit flip, input logic [1:0] stop);
    word_t w;
    logic  par;
    par  = (^d) ^ flip;
    w.d  = {1'b0, d};
    w.pe = ($countones({d, par}) % 2) != 0;
    w.fe = (stop != 2'b11);
    w.bk = (d == 7'd0) && (par == 1'b0) && w.fe;
    return w;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_line(input bit sel, input logic [15:0] bits, input int n);
    @(tick_ev);
    start_tick = tick_n;
    for (int i = 0; i < n; i++) begin
      if (sel) rx_b = bits[i];
      else     rx_a = bits[i];
      repeat (OS) @(tick_ev);
    end
    if (sel) rx_b = 1'b1;
    else     rx_a = 1'b1;
  endtask

  // Bounded wait for the next accepted word; an expired bound is a failure.
  task automatic get_word(input bit sel, input string name, output word_t w);
    int t;
    t = 0;
    w = '0;
    while (((sel ? qb.size() : qa.size()) == 0) && (t < 64)) begin
      @(tick_ev);
      t++;
    end
    if ((sel ? qb.size() : qa.size()) == 0) begin
      tests_run++;
      failed++;
      $display("FAIL %s: no word received within 64 ticks", name);
    end else if (sel) begin
      w = qb.pop_front();
    end else begin
      w = qa.pop_front();
    end
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    #1 data_ready = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (do_a !== 8'h00 || dv_a !== 1'b0) begin
      failed++;
      $display("FAIL reset_a_data: data_out=%h valid=%b want 00/0", do_a, dv_a);
    end
    tests_run++;
    if ({pe_a, fe_a, bk_a, ov_a, busy_a} !== 5'b0) begin
      failed++;
      $display("FAIL reset_a_flags: pe/fe/bk/ov/busy=%b want 00000", {pe_a, fe_a, bk_a, ov_a, busy_a});
    end
    tests_run++;
    if ({do_b, dv_b, pe_b, fe_b, bk_b, ov_b, busy_b} !== 13'b0) begin
      failed++;
      $display("FAIL reset_b: outputs=%b want all 0", {do_b, dv_b, pe_b, fe_b, bk_b, ov_b, busy_b});
    end
    rst = 1'b1;
    repeat (4) @(tick_ev);
  endtask

  task automatic test_basic;
    word_t w, e;
    int    off;
    set_ready(1'b1);
    qa.delete();
    rises_a = 0;
    e = model_8n1(8'hA5);
    send_line(1'b0, frame_8n1(8'hA5), 10);
    get_word(1'b0, "basic_a5", w);
    tests_run++;
    if (w !== e) begin
      failed++;
      $display("FAIL basic_a5: got %h/%b%b%b want %h/%b%b%b", w.d, w.pe, w.fe, w.bk, e.d, e.pe, e.fe, e.bk);
    end
    repeat (8) @(tick_ev);
    tests_run++;
    if (rises_a !== 1) begin
      failed++;
      $display("FAIL basic_pulses: data_valid rose %0d times want 1", rises_a);
    end
    // Stop bit spans line ticks 144..159; its tick 9 is 153, plus synchroniser lag.
    off = rise_tick_a - start_tick;
    tests_run++;
    if (!rise_on_tick_a || off < 153 || off > 156) begin
      failed++;
      $display("FAIL basic_timing: rise after tick=%b at offset %0d want 1 and 153..156", rise_on_tick_a, off);
    end
    tests_run++;
    if (busy_a !== 1'b0) begin
      failed++;
      $display("FAIL basic_busy: busy=%b want 0", busy_a);
    end
  endtask

  task automatic test_glitch;
    word_t w;
    qa.delete();
    rises_a = 0;
    busy_seen_a = 1'b0;
    @(tick_ev);
    rx_a = 1'b0;
    repeat (4) @(tick_ev);
    rx_a = 1'b1;
    repeat (40) @(tick_ev);
    tests_run++;
    if (rises_a !== 0 || qa.size() !== 0) begin
      failed++;
      $display("FAIL glitch_no_word: rises=%0d words=%0d want 0/0", rises_a, qa.size());
    end
    tests_run++;
    if (busy_seen_a !== 1'b1 || busy_a !== 1'b0) begin
      failed++;
      $display("FAIL glitch_busy: seen=%b now=%b want 1/0", busy_seen_a, busy_a);
    end
    send_line(1'b0, frame_8n1(8'h3C), 10);
    get_word(1'b0, "glitch_3c", w);
    tests_run++;
    if (w !== model_8n1(8'h3C)) begin
      failed++;
      $display("FAIL glitch_3c: got %h/%b%b%b want 3c/000", w.d, w.pe, w.fe, w.bk);
    end
  endtask

  task automatic test_7e2;
    word_t w, e;
    bit    flips[3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0] stops[3] = '{2'b11, 2'b11, 2'b01};
    qb.delete();
    for (int i = 0; i < 3; i++) begin
      e = model_7e2(7'h41, flips[i], stops[i]);
      send_line(1'b1, frame_7e2(7'h41, flips[i], stops[i]), 11);
      get_word(1'b1, "7e2_41", w);
      tests_run++;
      if (w !== e) begin
        failed++;
        $display("FAIL 7e2_41 case %0d: got %h pe=%b fe=%b bk=%b want %h pe=%b fe=%b bk=%b",
                 i, w.d, w.pe, w.fe, w.bk, e.d, e.pe, e.fe, e.bk);
      end
      repeat (8) @(tick_ev);
    end
  endtask

  task automatic test_overrun;
    set_ready(1'b0);
    ov_cnt_a = 0;
    send_line(1'b0, frame_8n1(8'h11), 10);
    send_line(1'b0, frame_8n1(8'h22), 10);
    repeat (8) @(tick_ev);
    tests_run++;
    if (dv_a !== 1'b1 || do_a !== 8'h11) begin
      failed++;
      $display("FAIL overrun_hold: valid=%b data=%h want 1/11", dv_a, do_a);
    end
    tests_run++;
    if (ov_cnt_a !== 1) begin
      failed++;
      $display("FAIL overrun_pulse: overrun high for %0d clks want 1", ov_cnt_a);
    end
    set_ready(1'b1);
    @(negedge clk);
    #1;
    tests_run++;
    if (dv_a !== 1'b0) begin
      failed++;
      $display("FAIL overrun_drop: valid=%b one cycle after ready want 0", dv_a);
    end
    qa.delete();
  endtask

  task automatic test_break;
    word_t w;
    qa.delete();
    rises_a = 0;
    @(tick_ev);
    rx_a = 1'b0;
    repeat (30 * OS) @(tick_ev);
    rx_a = 1'b1;
    repeat (2 * OS) @(tick_ev);
    get_word(1'b0, "break_word", w);
    tests_run++;
    if (w !== word_t'{d: 8'h00, pe: 1'b0, fe: 1'b1, bk: 1'b1} || rises_a !== 1) begin
      failed++;
      $display("FAIL break_word: got %h fe=%b bk=%b words=%0d want 00 fe=1 bk=1 words=1", w.d, w.fe, w.bk, rises_a);
    end
    send_line(1'b0, frame_8n1(8'h55), 10);
    get_word(1'b0, "break_55", w);
    tests_run++;
    if (w !== model_8n1(8'h55)) begin
      failed++;
      $display("FAIL break_55: got %h/%b%b%b want 55/000", w.d, w.pe, w.fe, w.bk);
    end
  endtask

  task automatic test_reset_mid;
    word_t w;
    qa.delete();
    send_line(1'b0, frame_8n1(8'hFF), 5);
    tests_run++;
    if (busy_a !== 1'b1) begin
      failed++;
      $display("FAIL rstmid_busy: busy=%b before reset want 1", busy_a);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if ({do_a, dv_a, pe_a, fe_a, bk_a, ov_a, busy_a} !== 14'b0) begin
      failed++;
      $display("FAIL rstmid_outputs: data=%h flags=%b want 00/000000", do_a, {dv_a, pe_a, fe_a, bk_a, ov_a, busy_a});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(tick_ev);
    send_line(1'b0, frame_8n1(8'h81), 10);
    get_word(1'b0, "rstmid_81", w);
    tests_run++;
    if (w !== model_8n1(8'h81)) begin
      failed++;
      $display("FAIL rstmid_81: got %h/%b%b%b want 81/000", w.d, w.pe, w.fe, w.bk);
    end
  endtask

  task automatic test_random;
    word_t      w, e;
    logic [7:0] d8;
    logic [6:0] d7;
    bit         flip;
    logic [1:0] stop;
    qa.delete();
    qb.delete();
    for (int i = 0; i < 6; i++) begin
      d8 = 8'($urandom_range(0, 255));
      send_line(1'b0, frame_8n1(d8), 10);
      get_word(1'b0, "rand_8n1", w);
      tests_run++;
      if (w !== model_8n1(d8)) begin
        failed++;
        $display("FAIL rand_8n1 %0d: got %h/%b%b%b want %h/000", i, w.d, w.pe, w.fe, w.bk, d8);
      end
      d7   = 7'($urandom_range(0, 127));
      flip = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      e    = model_7e2(d7, flip, stop);
      send_line(1'b1, frame_7e2(d7, flip, stop), 11);
      get_word(1'b1, "rand_7e2", w);
      tests_run++;
      if (w !== e) begin
        failed++;
        $display("FAIL rand_7e2 %0d: got %h pe=%b fe=%b bk=%b want %h pe=%b fe=%b bk=%b",
                 i, w.d, w.pe, w.fe, w.bk, e.d, e.pe, e.fe, e.bk);
      end
      repeat (8) @(tick_ev);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_7e2();
    test_overrun();
    test_break();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
